// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard: forward-select codes, memory FSM
// states and the per-stage control-tag bundle.
package hazard_scoreboard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DONE = 2'b10
    } mem_state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_access;
        logic pcsrc;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // M-stage ALU result beats the older W-stage result.
    function automatic logic [1:0] fwd_sel(input logic m_hit, input logic w_hit);
        if (m_hit)
            return FWD_MEM;
        else if (w_hit)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side fields in, pipeline control out, between datapath (master) and
// hazard unit (slave).
interface hazard_scoreboard_if #(parameter int AW = 4);

    logic [AW-1:0] ra1d;
    logic [AW-1:0] ra2d;
    logic [AW-1:0] wa3d;
    logic          reg_write_d;
    logic          mem_to_reg_d;
    logic          mem_access_d;
    logic          pcsrc_d;
    logic          branch_taken_e;

    logic          stall_f;
    logic          stall_d;
    logic          stall_e;
    logic          stall_m;
    logic          flush_d;
    logic          flush_e;
    logic          flush_w;
    logic [1:0]    forward_ae;
    logic [1:0]    forward_be;

    modport master (
        output ra1d, ra2d, wa3d, reg_write_d, mem_to_reg_d, mem_access_d,
               pcsrc_d, branch_taken_e,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
               forward_ae, forward_be
    );

    modport slave (
        input  ra1d, ra2d, wa3d, reg_write_d, mem_to_reg_d, mem_access_d,
               pcsrc_d, branch_taken_e,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
               forward_ae, forward_be
    );

endinterface

// File: rtl/hazard_scoreboard_tag_stage.sv
// One shadow tag register of the scoreboard; hold takes priority over clear.
module hazard_scoreboard_tag_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         hold,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= '0;
        else if (hold)
            q <= q;
        else if (clear)
            q <= '0;
        else
            q <= d;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the F/D/E/M/W pipeline: shadows destination tags of in-flight
// instructions and derives stall, flush and forward selects, with multi-cycle memory freeze.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int AW      = 4,
    parameter int PC_REG  = 15,
    parameter int MEM_LAT = 0
) (
    input  logic              clk,
    input  logic              reset,
    hazard_scoreboard_if.slave hz
);

    localparam logic [AW-1:0] PC_ADDR = AW'(PC_REG);
    localparam int CNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam int ET_W  = 3 * AW + CTRL_W;
    localparam int MT_W  = AW + CTRL_W;
    localparam int WT_W  = AW + 1;

    ctrl_t         ctrl_d, ctrl_e, ctrl_m;
    logic [AW-1:0] ra1e, ra2e, wa3e, wa3m, wa3w;
    logic          reg_write_w;
    logic [ET_W-1:0] e_q;
    logic [MT_W-1:0] m_q;
    logic [WT_W-1:0] w_q;

    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w;
    logic mstall, mem_trigger, ldr, pcw;
    logic m_hit_a, w_hit_a, m_hit_b, w_hit_b;

    mem_state_t       state;
    logic [CNT_W-1:0] cnt;

    assign ctrl_d = '{reg_write:  hz.reg_write_d,
                      mem_to_reg: hz.mem_to_reg_d,
                      mem_access: hz.mem_access_d,
                      pcsrc:      hz.pcsrc_d};

    // W only needs what forwarding reads; its pcsrc deliberately raises nothing.
    hazard_scoreboard_tag_stage #(.W(ET_W)) e_stage (
        .clk(clk), .reset(reset), .hold(stall_e), .clear(flush_e),
        .d({hz.ra1d, hz.ra2d, hz.wa3d, ctrl_d}), .q(e_q)
    );
    hazard_scoreboard_tag_stage #(.W(MT_W)) m_stage (
        .clk(clk), .reset(reset), .hold(stall_m), .clear(1'b0),
        .d({wa3e, ctrl_e}), .q(m_q)
    );
    hazard_scoreboard_tag_stage #(.W(WT_W)) w_stage (
        .clk(clk), .reset(reset), .hold(1'b0), .clear(flush_w),
        .d({wa3m, ctrl_m.reg_write}), .q(w_q)
    );

    assign {ra1e, ra2e, wa3e, ctrl_e} = e_q;
    assign {wa3m, ctrl_m}             = m_q;
    assign {wa3w, reg_write_w}        = w_q;

    // The DONE visit lets the completed access leave M without re-triggering.
    assign mem_trigger = (state == S_IDLE) && ctrl_m.mem_access && (MEM_LAT > 0);
    assign mstall      = mem_trigger || (state == S_WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_trigger) begin
                        cnt   <= CNT_W'(MEM_LAT - 1);
                        state <= (MEM_LAT > 1) ? S_WAIT : S_DONE;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ldr = ctrl_e.mem_to_reg && ctrl_e.reg_write && (wa3e != PC_ADDR) &&
                 ((hz.ra1d == wa3e) || (hz.ra2d == wa3e));
    assign pcw = hz.pcsrc_d || ctrl_e.pcsrc || ctrl_m.pcsrc;

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (mstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (hz.branch_taken_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (ldr) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else if (pcw) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
        end
    end

    // Loads still in M have no result yet, so only ALU results forward from M.
    assign m_hit_a = (ra1e != PC_ADDR) && ctrl_m.reg_write && !ctrl_m.mem_to_reg && (wa3m == ra1e);
    assign w_hit_a = (ra1e != PC_ADDR) && reg_write_w && (wa3w == ra1e);
    assign m_hit_b = (ra2e != PC_ADDR) && ctrl_m.reg_write && !ctrl_m.mem_to_reg && (wa3m == ra2e);
    assign w_hit_b = (ra2e != PC_ADDR) && reg_write_w && (wa3w == ra2e);

    assign hz.forward_ae = fwd_sel(m_hit_a, w_hit_a);
    assign hz.forward_be = fwd_sel(m_hit_b, w_hit_b);

    assign hz.stall_f = stall_f;
    assign hz.stall_d = stall_d;
    assign hz.stall_e = stall_e;
    assign hz.stall_m = stall_m;
    assign hz.flush_d = flush_d;
    assign hz.flush_e = flush_e;
    assign hz.flush_w = flush_w;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vector bench: single-cycle-memory hazard unit driven through a short
// program table, plus a MEM_LAT=3 instance for freeze and reset-abort sequences.
module tb_hazard_scoreboard;

    typedef struct {
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [3:0] wa3;
        logic [3:0] ctrl;
        logic       bt;
        logic [6:0] flags;
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

    // ctrl = {reg_write, mem_to_reg, mem_access, pcsrc}
    localparam logic [3:0] C_NOP   = 4'b0000;
    localparam logic [3:0] C_ALU   = 4'b1000;
    localparam logic [3:0] C_LDR   = 4'b1110;
    localparam logic [3:0] C_STR   = 4'b0010;
    localparam logic [3:0] C_MOVPC = 4'b1001;

    // flags = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] SF   = 7'b1000000;
    localparam logic [6:0] SD   = 7'b0100000;
    localparam logic [6:0] SE   = 7'b0010000;
    localparam logic [6:0] SM   = 7'b0001000;
    localparam logic [6:0] FD   = 7'b0000100;
    localparam logic [6:0] FE   = 7'b0000010;
    localparam logic [6:0] FW   = 7'b0000001;
    localparam logic [6:0] MSTALL = SF | SD | SE | SM | FW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vec_count = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.AW(4)) bus0 ();
    hazard_scoreboard_if #(.AW(4)) bus3 ();

    hazard_scoreboard #(.AW(4), .PC_REG(15), .MEM_LAT(0)) dut0 (
        .clk(clk), .reset(reset), .hz(bus0)
    );
    hazard_scoreboard #(.AW(4), .PC_REG(15), .MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .hz(bus3)
    );

    function automatic vec_t mk(input logic [3:0] ra1, input logic [3:0] ra2,
                                input logic [3:0] wa3, input logic [3:0] ctrl,
                                input logic bt, input logic [6:0] flags,
                                input logic [1:0] fa, input logic [1:0] fb);
        vec_t v;
        v.ra1 = ra1; v.ra2 = ra2; v.wa3 = wa3; v.ctrl = ctrl;
        v.bt = bt; v.flags = flags; v.fa = fa; v.fb = fb;
        return v;
    endfunction

    task automatic apply_stimulus(input int sel, input vec_t v);
        if (sel == 0) begin
            bus0.ra1d = v.ra1; bus0.ra2d = v.ra2; bus0.wa3d = v.wa3;
            bus0.reg_write_d = v.ctrl[3]; bus0.mem_to_reg_d = v.ctrl[2];
            bus0.mem_access_d = v.ctrl[1]; bus0.pcsrc_d = v.ctrl[0];
            bus0.branch_taken_e = v.bt;
        end else begin
            bus3.ra1d = v.ra1; bus3.ra2d = v.ra2; bus3.wa3d = v.wa3;
            bus3.reg_write_d = v.ctrl[3]; bus3.mem_to_reg_d = v.ctrl[2];
            bus3.mem_access_d = v.ctrl[1]; bus3.pcsrc_d = v.ctrl[0];
            bus3.branch_taken_e = v.bt;
        end
    endtask

    function automatic logic [10:0] outputs_of(input int sel);
        if (sel == 0)
            return {bus0.stall_f, bus0.stall_d, bus0.stall_e, bus0.stall_m, bus0.flush_d,
                    bus0.flush_e, bus0.flush_w, bus0.forward_ae, bus0.forward_be};
        else
            return {bus3.stall_f, bus3.stall_d, bus3.stall_e, bus3.stall_m, bus3.flush_d,
                    bus3.flush_e, bus3.flush_w, bus3.forward_ae, bus3.forward_be};
    endfunction

    task automatic check_output(input string name, input int sel, input logic [6:0] flags,
                                input logic [1:0] fa, input logic [1:0] fb);
        logic [10:0] act;
        act = outputs_of(sel);
        vec_count++;
        if (act !== {flags, fa, fb}) begin
            miscompares++;
            $display("[TB] FAIL %s: got sf,sd,se,sm,fd,fe,fw=%b fa=%b fb=%b, want %b fa=%b fb=%b",
                     name, act[10:4], act[3:2], act[1:0], flags, fa, fb);
        end
    endtask

    task automatic run_vec(input string name, input int sel, input vec_t v);
        @(negedge clk);
        apply_stimulus(sel, v);
        #1;
        check_output(name, sel, v.flags, v.fa, v.fb);
    endtask

    vec_t prog0[$];
    vec_t prog3[$];
    vec_t rst3[$];
    vec_t nop;

    initial begin
        nop = mk(0, 0, 0, C_NOP, 0, NONE, 2'b00, 2'b00);
        apply_stimulus(0, nop);
        apply_stimulus(3, nop);
        repeat (2) @(negedge clk);
        check_output("reset_dut0", 0, NONE, 2'b00, 2'b00);
        check_output("reset_dut3", 3, NONE, 2'b00, 2'b00);
        reset = 1'b1;

        // ADD r1 -> SUB uses r1 from M
        prog0.push_back(mk(2, 3, 1, C_ALU, 0, NONE, 2'b00, 2'b00));
        prog0.push_back(mk(1, 3, 2, C_ALU, 0, NONE, 2'b00, 2'b00));
        prog0.push_back(mk(0, 0, 0, C_NOP, 0, NONE, 2'b10, 2'b00));
        prog0.push_back(mk(0, 0, 0, C_NOP, 0, NONE, 2'b00, 2'b00));
        // ADD r1, NOP, ORR r4,r5,r1 -> operand B from W
        prog0.push_back(mk(6, 7, 1, C_ALU, 0, NONE, 2'b00, 2'b00));
        prog0.push_back(mk(0, 0, 0, C_NOP, 0, NONE, 2'b00, 2'b00));
        prog0.push_back(mk(5, 1, 4, C_ALU, 0, NONE, 2'b00, 2'b00));
        prog0.push_back(mk(0, 0, 0, C_NOP, 0, NONE, 2'b00, 2'b01));
        // r1 written in both M and W -> M wins
        prog0.push_back(mk(2, 2, 1, C_ALU, 0, NONE, 2'b00, 2'b00));
        prog0.push_back(mk(3, 3, 1, C_ALU, 0, NONE, 2'b00, 2'b00));
        prog0.push_back(mk(1, 1, 6, C_ALU, 0, NONE, 2'b00, 2'b00));
        prog0.push_back(mk(0, 0, 0, C_NOP, 0, NONE, 2'b10, 2'b10));
        // LDR r2 then ADD r3,r2,r2 -> one load-use bubble, then W forward
        prog0.push_back(mk(4, 0, 2, C_LDR, 0, NONE, 2'b00, 2'b00));
        prog0.push_back(mk(2, 2, 3, C_ALU, 0, SF | SD | FE, 2'b00, 2'b00));
        prog0.push_back(mk(2, 2, 3, C_ALU, 0, NONE, 2'b00, 2'b00));
        prog0.push_back(mk(0, 0, 0, C_NOP, 0, NONE, 2'b01, 2'b01));
        // branch taken beats a load-use in D
        prog0.push_back(mk(6, 0, 5, C_LDR, 0, NONE, 2'b00, 2'b00));
        prog0.push_back(mk(5, 0, 7, C_ALU, 1, FD | FE, 2'b00, 2'b00));
        prog0.push_back(mk(0, 0, 0, C_NOP, 0, NONE, 2'b00, 2'b00));
        // MOV pc,r0 -> fetch held while pcsrc is in D, E, M
        prog0.push_back(mk(0, 0, 15, C_MOVPC, 0, SF | FD, 2'b00, 2'b00));
        prog0.push_back(mk(0, 0, 0, C_NOP, 0, SF | FD, 2'b00, 2'b00));
        prog0.push_back(mk(0, 0, 0, C_NOP, 0, SF | FD, 2'b00, 2'b00));
        prog0.push_back(mk(9, 9, 8, C_ALU, 0, NONE, 2'b00, 2'b00));
        // r15 writer in M, r15 reader in E -> no forward
        prog0.push_back(mk(1, 2, 15, C_ALU, 0, NONE, 2'b00, 2'b00));
        prog0.push_back(mk(15, 15, 9, C_ALU, 0, NONE, 2'b00, 2'b00));
        prog0.push_back(mk(0, 0, 0, C_NOP, 0, NONE, 2'b00, 2'b00));
        prog0.push_back(mk(0, 0, 0, C_NOP, 0, NONE, 2'b00, 2'b00));
        // load into r15 followed by r15 reader -> no load-use stall
        prog0.push_back(mk(3, 0, 15, C_LDR, 0, NONE, 2'b00, 2'b00));
        prog0.push_back(mk(15, 4, 10, C_ALU, 0, NONE, 2'b00, 2'b00));
        prog0.push_back(mk(0, 0, 0, C_NOP, 0, NONE, 2'b00, 2'b00));
        prog0.push_back(mk(0, 0, 0, C_NOP, 0, NONE, 2'b00, 2'b00));
        // load-use and pcsrc in D together: stall wins, flush_d low
        prog0.push_back(mk(4, 0, 2, C_LDR, 0, NONE, 2'b00, 2'b00));
        prog0.push_back(mk(0, 2, 15, C_MOVPC, 0, SF | SD | FE, 2'b00, 2'b00));
        prog0.push_back(mk(0, 2, 15, C_MOVPC, 0, SF | FD, 2'b00, 2'b00));
        prog0.push_back(mk(0, 0, 0, C_NOP, 0, SF | FD, 2'b00, 2'b01));
        prog0.push_back(mk(0, 0, 0, C_NOP, 0, SF | FD, 2'b00, 2'b00));
        prog0.push_back(mk(0, 0, 0, C_NOP, 0, NONE, 2'b00, 2'b00));

        // MEM_LAT=3: STR in M freezes the pipe for 3 cycles; branch ignored meanwhile
        prog3.push_back(mk(1, 2, 0, C_STR, 0, NONE, 2'b00, 2'b00));
        prog3.push_back(mk(6, 7, 5, C_ALU, 0, NONE, 2'b00, 2'b00));
        prog3.push_back(mk(5, 9, 8, C_ALU, 0, MSTALL, 2'b00, 2'b00));
        prog3.push_back(mk(5, 9, 8, C_ALU, 1, MSTALL, 2'b00, 2'b00));
        prog3.push_back(mk(5, 9, 8, C_ALU, 1, MSTALL, 2'b00, 2'b00));
        prog3.push_back(mk(5, 9, 8, C_ALU, 0, NONE, 2'b00, 2'b00));
        prog3.push_back(mk(0, 0, 0, C_NOP, 0, NONE, 2'b10, 2'b00));
        prog3.push_back(mk(0, 0, 0, C_NOP, 0, NONE, 2'b00, 2'b00));

        rst3.push_back(mk(1, 2, 0, C_STR, 0, NONE, 2'b00, 2'b00));
        rst3.push_back(mk(0, 0, 0, C_NOP, 0, NONE, 2'b00, 2'b00));
        rst3.push_back(mk(0, 0, 0, C_NOP, 0, MSTALL, 2'b00, 2'b00));
        rst3.push_back(mk(0, 0, 0, C_NOP, 0, MSTALL, 2'b00, 2'b00));

        foreach (prog0[i]) run_vec($sformatf("prog0_%0d", i), 0, prog0[i]);
        foreach (prog3[i]) run_vec($sformatf("mem3_%0d", i), 3, prog3[i]);
        foreach (rst3[i])  run_vec($sformatf("rst3_%0d", i), 3, rst3[i]);

        // Reset lands while the FSM sits in WAIT: outputs must drop immediately
        #2;
        reset = 1'b0;
        #1;
        check_output("reset_mid_wait", 3, NONE, 2'b00, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        run_vec("after_reset_0", 3, nop);
        run_vec("after_reset_1", 3, nop);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
